// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_rx_state_t;

    // Tick count at which the start bit is re-checked: the middle of the bit period.
    function automatic int sample_mid(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; width and reset value are parameters.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver: finds the start bit on the oversampled tick, samples each bit at its
// centre, and presents completed words with framing/parity/overrun status.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy,
    output uart_rx_state_t       dbg_state
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_MID     = TW'(sample_mid(OVERSAMPLE));
    localparam logic [BW-1:0] DB_LAST   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    logic rx_s;
    logic rx_s_d;
    logic fall;

    uart_rx_state_t        state_q, state_d;
    logic [TW-1:0]         tcnt_q, tcnt_d, tcnt_inc;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  done_q, done_d;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign fall     = rx_s_d & ~rx_s;
    assign tcnt_inc = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s_d  <= 1'b1;
            state_q <= IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rx_s_d  <= rx_s;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
        end
    end

    // bcnt counts data bits in DATA and stop bits in STOP; done_d marks the final stop sample.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tcnt_q == T_MID) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            tcnt_d  = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_inc;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_q == T_LAST) begin
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bcnt_q == DB_LAST) begin
                            bcnt_d  = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_q == T_LAST) begin
                        perr_d  = ((^shreg_q) ^ rx_s) != ODD;
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_q == T_LAST) begin
                        if (!rx_s || bcnt_q == STOP_LAST) begin
                            ferr_d  = ~rx_s;
                            done_d  = 1'b1;
                            bcnt_d  = '0;
                            // A low stop means the line may be held low; wait it out in BREAK.
                            state_d = rx_s ? IDLE : BREAK;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake: a word transfers on any clk edge where rx_valid & rx_ready are both high.
    // rx_valid, once raised, stays high and rx_data/flags stay stable until that transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg_q;
                    frame_err  <= ferr_q;
                    parity_err <= perr_q;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboarded bench: an 8N1 receiver (a) and an 8E1 receiver (b) share clock, reset and tick.
module tb_uart_rx_oversampled;
    import uart_pkg::*;

    localparam int OS  = 16;
    localparam int TPB = 4 * OS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic baud_tick = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic ready_a = 1'b0;
    logic ready_b = 1'b1;
    int   mode_a = 0;

    logic [7:0]     rx_data_a, rx_data_b;
    logic           rx_valid_a, rx_valid_b;
    logic           frame_err_a, frame_err_b;
    logic           parity_err_a, parity_err_b;
    logic           overrun_a, overrun_b;
    logic           busy_a, busy_b;
    uart_rx_state_t dbg_a, dbg_b;

    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    logic [9:0] ea, eb;
    int n_vec = 0;
    int n_fail = 0;
    int ov_a = 0;
    int ov_b = 0;
    int ov_base;

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(ready_a),
        .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a),
        .busy(busy_a), .dbg_state(dbg_a)
    );

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(ready_b),
        .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b),
        .busy(busy_b), .dbg_state(dbg_b)
    );

    // Clock and baud tick (one tick every 4 clk).
    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            baud_tick = (div == 3);
            div = (div == 3) ? 0 : div + 1;
        end
    end

    // Consumer for receiver a: 0 = stalled, 1 = always ready, otherwise random.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (mode_a)
                0:       ready_a = 1'b0;
                1:       ready_a = 1'b1;
                default: ready_a = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: even parity means the data ones plus the parity bit total an even count.
    function automatic logic model_perr(input logic [7:0] d, input logic pbit);
        int ones;
        ones = $countones(d) + int'(pbit);
        return (ones % 2) != 0;
    endfunction

    task automatic push(input bit sel, input logic [7:0] d, input logic ferr, input logic perr);
        if (sel) exp_b.push_back({d, ferr, perr});
        else     exp_a.push_back({d, ferr, perr});
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (TPB) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input bit sel, input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(sel, 1'b1);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                              input bit flip, input logic stop_v);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_en) drive_bit(sel, (^d) ^ flip);
        drive_bit(sel, stop_v);
    endtask

    // Monitors: pop and compare whenever a word transfers; count overrun pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (overrun_a) ov_a++;
                if (rx_valid_a && ready_a) begin
                    if (exp_a.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL a_unexpected_word: got 0x%0h, expected none", rx_data_a);
                    end else begin
                        ea = exp_a.pop_front();
                        check("a_data", rx_data_a, ea[9:2]);
                        check("a_frame_err", frame_err_a, ea[1]);
                        check("a_parity_err", parity_err_a, ea[0]);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (overrun_b) ov_b++;
                if (rx_valid_b && ready_b) begin
                    if (exp_b.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL b_unexpected_word: got 0x%0h, expected none", rx_data_b);
                    end else begin
                        eb = exp_b.pop_front();
                        check("b_data", rx_data_b, eb[9:2]);
                        check("b_frame_err", frame_err_b, eb[1]);
                        check("b_parity_err", parity_err_b, eb[0]);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       stop_v;
        bit         flip;

        wait_clk(5);
        check("rst_valid", rx_valid_a, 0);
        check("rst_data", rx_data_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_flags", {frame_err_a, parity_err_a, overrun_a}, 0);
        check("rst_state", 32'(dbg_a), 32'(IDLE));
        rst_n = 1'b1;
        mode_a = 1;
        idle(0, 1);

        // Clean 8N1 frame.
        push(0, 8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 0, 0, 1'b1);
        idle(0, 2);
        check("a5_busy_after", busy_a, 0);

        // Start-bit glitch: 5 ticks low.
        rx_a = 1'b0;
        wait_clk(10);
        check("glitch_busy_high", busy_a, 1);
        wait_clk(10);
        rx_a = 1'b1;
        wait_clk(2 * TPB);
        check("glitch_busy_low", busy_a, 0);
        check("glitch_no_valid", rx_valid_a, 0);

        // Line held low for three frame times: exactly one errored zero word.
        push(0, 8'h00, 1'b1, 1'b0);
        rx_a = 1'b0;
        wait_clk(30 * TPB);
        check("break_busy", busy_a, 1);
        rx_a = 1'b1;
        idle(0, 2);
        check("break_idle", busy_a, 0);

        // Overrun: second word arrives while the first is still unaccepted.
        mode_a = 0;
        ov_base = ov_a;
        push(0, 8'h31, 1'b0, 1'b0);
        send_frame(0, 8'h31, 0, 0, 1'b1);
        idle(0, 1);
        send_frame(0, 8'h32, 0, 0, 1'b1);
        idle(0, 2);
        check("ovr_pulse_count", ov_a - ov_base, 1);
        check("ovr_kept_valid", rx_valid_a, 1);
        check("ovr_kept_data", rx_data_a, 8'h31);
        mode_a = 1;
        wait_clk(4);

        // Ready raised exactly in the cycle the second word completes: no overrun.
        mode_a = 0;
        ov_base = ov_a;
        push(0, 8'h41, 1'b0, 1'b0);
        send_frame(0, 8'h41, 0, 0, 1'b1);
        idle(0, 1);
        push(0, 8'h42, 1'b0, 1'b0);
        fork
            send_frame(0, 8'h42, 0, 0, 1'b1);
            begin
                int k;
                k = 0;
                while (!busy_a && k < 400) begin
                    wait_clk(1);
                    k++;
                end
                check("ovr2_busy_rise", busy_a, 1);
                k = 0;
                while (busy_a && k < 1200) begin
                    wait_clk(1);
                    k++;
                end
                check("ovr2_busy_fall", busy_a, 0);
                mode_a = 1;
            end
        join
        idle(0, 2);
        check("ovr2_no_pulse", ov_a - ov_base, 0);

        // Reset in the middle of data bit 4 while a word is held.
        mode_a = 0;
        send_frame(0, 8'h11, 0, 0, 1'b1);
        idle(0, 1);
        check("pre_rst_valid", rx_valid_a, 1);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b0 ^ ((8'h22 >> i) & 1));
        rx_a = 1'b0;
        wait_clk(TPB / 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rx_valid_a, 0);
        check("mid_rst_data", rx_data_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_flags", {frame_err_a, parity_err_a, overrun_a}, 0);
        rx_a = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        mode_a = 1;
        idle(0, 1);
        push(0, 8'h5A, 1'b0, 1'b0);
        send_frame(0, 8'h5A, 0, 0, 1'b1);
        idle(0, 2);

        // Random 8N1 traffic with a random consumer and occasional bad stop bits.
        mode_a = 2;
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom);
            stop_v = ($urandom_range(0, 4) != 0);
            push(0, d, ~stop_v, 1'b0);
            send_frame(0, d, 0, 0, stop_v);
            idle(0, $urandom_range(1, 3));
        end
        idle(0, 1);

        // 8E1: parity bit flipped on 0x03.
        push(1, 8'h03, 1'b0, model_perr(8'h03, 1'b1));
        send_frame(1, 8'h03, 1, 1, 1'b1);
        idle(1, 2);

        // Random 8E1 traffic.
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            flip = ($urandom_range(0, 2) == 0);
            stop_v = ($urandom_range(0, 4) != 0);
            push(1, d, ~stop_v, model_perr(d, (^d) ^ flip));
            send_frame(1, d, 1, flip, stop_v);
            idle(1, $urandom_range(1, 3));
        end
        idle(1, 3);

        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);
        check("a_total_overruns", ov_a, 1);
        check("b_total_overruns", ov_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
